// File: rtl/vga_scan_sequencer.sv
// Scan source for the munch/text display path: 640x480@60 VGA timing plus the
// per-frame animation counter and the text word selector.
module vga_scan_sequencer #(
  parameter int H_DISPLAY       = 640,
  parameter int H_FRONT         = 16,
  parameter int H_SYNC          = 96,
  parameter int H_BACK          = 48,
  parameter int V_DISPLAY       = 480,
  parameter int V_FRONT         = 10,
  parameter int V_SYNC          = 2,
  parameter int V_BACK          = 33,
  parameter int FRAMES_PER_WORD = 120
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       pause,
  input  logic       step,
  output logic [9:0] hpos,
  output logic [9:0] vpos,
  output logic       hsync,
  output logic       vsync,
  output logic       display_on,
  output logic       frame_tick,
  output logic [6:0] counter,
  output logic [1:0] selector
);

  localparam int H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;
  localparam int DIV_W   = (FRAMES_PER_WORD > 1) ? $clog2(FRAMES_PER_WORD) : 1;

  localparam logic [9:0] H_LAST     = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST     = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_VIS      = 10'(H_DISPLAY);
  localparam logic [9:0] V_VIS      = 10'(V_DISPLAY);
  localparam logic [9:0] HS_START   = 10'(H_DISPLAY + H_FRONT);
  localparam logic [9:0] HS_END     = 10'(H_DISPLAY + H_FRONT + H_SYNC);
  localparam logic [9:0] VS_START   = 10'(V_DISPLAY + V_FRONT);
  localparam logic [9:0] VS_END     = 10'(V_DISPLAY + V_FRONT + V_SYNC);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(FRAMES_PER_WORD - 1);

  logic [9:0]       hpos_next;
  logic [9:0]       vpos_next;
  logic [DIV_W-1:0] divider;
  logic             frame_end;
  logic             manual_adv;
  logic             word_adv;

  // Sync/blank flags are decoded from the next position so they line up with it.
  always_comb begin
    hpos_next = hpos + 10'd1;
    vpos_next = vpos;
    if (hpos == H_LAST) begin
      hpos_next = 10'd0;
      vpos_next = (vpos == V_LAST) ? 10'd0 : vpos + 10'd1;
    end
  end

  // frame_tick is high exactly on the last clock of the frame, so it doubles
  // as the frame-end strobe for the animation state.
  always_comb begin
    frame_end  = frame_tick & ~pause;
    manual_adv = step & ~pause;
    word_adv   = manual_adv | (frame_end & (divider == DIV_LAST));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      hpos       <= 10'd0;
      vpos       <= 10'd0;
      hsync      <= 1'b1;
      vsync      <= 1'b1;
      display_on <= 1'b1;
      frame_tick <= 1'b0;
      counter    <= 7'd0;
      selector   <= 2'd0;
      divider    <= '0;
    end else begin
      hpos       <= hpos_next;
      vpos       <= vpos_next;
      hsync      <= ~((hpos_next >= HS_START) && (hpos_next < HS_END));
      vsync      <= ~((vpos_next >= VS_START) && (vpos_next < VS_END));
      display_on <= (hpos_next < H_VIS) && (vpos_next < V_VIS);
      frame_tick <= (hpos_next == H_LAST) && (vpos_next == V_LAST);
      if (frame_end) begin
        counter <= counter + 7'd1;
      end
      // A step coinciding with a divider rollover still advances only once.
      if (word_adv) begin
        selector <= selector + 2'd1;
        divider  <= '0;
      end else if (frame_end) begin
        divider <= divider + DIV_W'(1);
      end
    end
  end

endmodule
